// File: rtl/sram_arbiter.sv
// Two-master arbiter for one SRAM-like split-transaction port, with in-order response routing.
// Build option: define ARB_RR_EN for round-robin tie-break; otherwise data has fixed priority.
module sram_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    logic                   lock;
    logic                   lock_owner;
    logic                   last_owner;
    logic [OUTSTANDING-1:0] order_q;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;

    logic issue_en;
    logic grant_valid;
    logic grant;
    logic tie_pick;
    logic use_inst;
    logic accept;
    logic resp;
    logic head_owner;

    assign issue_en = (count < CNT_MAX) && !reset;

`ifdef ARB_RR_EN
    assign tie_pick = ~last_owner;
`else
    // last_owner is tracked in both builds; fixed priority simply ignores it.
    assign tie_pick = OWNER_DATA | (last_owner & 1'b0);
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant       = OWNER_DATA;
        if (issue_en) begin
            if (lock) begin
                grant_valid = 1'b1;
                grant       = lock_owner;
            end else if (inst_req && data_req) begin
                grant_valid = 1'b1;
                grant       = tie_pick;
            end else if (inst_req) begin
                grant_valid = 1'b1;
                grant       = OWNER_INST;
            end else if (data_req) begin
                grant_valid = 1'b1;
                grant       = OWNER_DATA;
            end
        end
    end

    // Without an inst grant the downstream fields always come from the data side.
    assign use_inst  = grant_valid && (grant == OWNER_INST);
    assign mem_req   = grant_valid && (use_inst ? inst_req : data_req);
    assign mem_wr    = use_inst ? inst_wr    : data_wr;
    assign mem_size  = use_inst ? inst_size  : data_size;
    assign mem_wstrb = use_inst ? inst_wstrb : data_wstrb;
    assign mem_addr  = use_inst ? inst_addr  : data_addr;
    assign mem_wdata = use_inst ? inst_wdata : data_wdata;

    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && (grant == OWNER_INST);
    assign data_addr_ok = accept && (grant == OWNER_DATA);

    // A response with nothing outstanding is dropped without touching state.
    assign head_owner   = order_q[rd_ptr];
    assign resp         = !reset && mem_data_ok && (count != '0);
    assign inst_data_ok = resp && (head_owner == OWNER_INST);
    assign data_data_ok = resp && (head_owner == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock       <= 1'b0;
            lock_owner <= OWNER_INST;
            last_owner <= OWNER_DATA;
            order_q    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (mem_req && !mem_addr_ok) begin
                lock       <= 1'b1;
                lock_owner <= grant;
            end else if (mem_addr_ok) begin
                lock <= 1'b0;
            end

            if (accept) begin
                order_q[wr_ptr] <= grant;
                wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                last_owner      <= grant;
            end

            if (resp) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end

            case ({accept, resp})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_sram_arbiter;

    localparam int OUTSTANDING = 2;
`ifdef ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    sram_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: owners of in-flight transactions in issue order, plus lock/last owner.
    logic [0:0] exp_q[$];
    bit m_lock = 1'b0;
    bit m_lock_owner = 1'b0;
    bit m_last = 1'b1;
    bit i_pend = 1'b0;
    bit d_pend = 1'b0;

    task automatic model_step();
        bit gv, g, sel_inst, ereq, eacc, eresp, head, issue;
        gv = 1'b0;
        g  = 1'b1;
        issue = (exp_q.size() < OUTSTANDING) && !reset;
        if (issue) begin
            if (m_lock) begin
                gv = 1'b1; g = m_lock_owner;
            end else if (inst_req && data_req) begin
                gv = 1'b1; g = RR_MODE ? !m_last : 1'b1;
            end else if (inst_req) begin
                gv = 1'b1; g = 1'b0;
            end else if (data_req) begin
                gv = 1'b1; g = 1'b1;
            end
        end
        ereq     = gv && (g ? data_req : inst_req);
        sel_inst = gv && !g;
        eacc     = ereq && mem_addr_ok;
        eresp    = !reset && mem_data_ok && (exp_q.size() != 0);
        head     = (exp_q.size() != 0) ? exp_q[0][0] : 1'b0;

        check("mem_req", 32'(mem_req), 32'(ereq));
        check("mem_addr", mem_addr, sel_inst ? inst_addr : data_addr);
        check("mem_wdata", mem_wdata, sel_inst ? inst_wdata : data_wdata);
        check("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}),
              sel_inst ? 32'({inst_wr, inst_size, inst_wstrb}) : 32'({data_wr, data_size, data_wstrb}));
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(eacc && !g));
        check("data_addr_ok", 32'(data_addr_ok), 32'(eacc && g));
        check("inst_data_ok", 32'(inst_data_ok), 32'(eresp && !head));
        check("data_data_ok", 32'(data_data_ok), 32'(eresp && head));
        check("rdata", inst_rdata ^ data_rdata ^ mem_rdata, mem_rdata);

        if (reset) begin
            exp_q.delete();
            m_lock = 1'b0;
            m_last = 1'b1;
            i_pend = 1'b0;
            d_pend = 1'b0;
        end else begin
            if (eresp) void'(exp_q.pop_front());
            if (eacc) begin
                exp_q.push_back(g);
                m_last = g;
            end
            if (ereq && !mem_addr_ok) begin
                m_lock = 1'b1; m_lock_owner = g;
            end else if (mem_addr_ok) begin
                m_lock = 1'b0;
            end
            i_pend = inst_req && !(eacc && !g);
            d_pend = data_req && !(eacc && g);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset = 1'b0;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = '0; inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_inputs();
        reset = ($urandom_range(0, 199) == 0);
        if (!i_pend) begin
            inst_req = ($urandom_range(0, 99) < 60); inst_wr = 1'($urandom_range(0, 1));
            inst_size = 2'($urandom_range(0, 2)); inst_wstrb = 4'($urandom);
            inst_addr = $urandom; inst_wdata = $urandom;
        end
        if (!d_pend) begin
            data_req = ($urandom_range(0, 99) < 60); data_wr = 1'($urandom_range(0, 1));
            data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
            data_addr = $urandom; data_wdata = $urandom;
        end
        mem_addr_ok = ($urandom_range(0, 99) < 55);
        mem_data_ok = ($urandom_range(0, 99) < 45);
        mem_rdata   = $urandom;
    endtask

    logic [3:0] pat;

    initial begin
        clr();
        reset = 1'b1;
        #1;
        tick();
        #3;
        check("reset_mem_req", 32'(mem_req), 32'd0);
        tick();

        // Single inst read, response two cycles after accept.
        do_reset();
        clr(); inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
        #3;
        check("s1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        check("s1_mem_addr", mem_addr, 32'h1c000000);
        tick();
        clr(); tick();
        clr(); mem_data_ok = 1'b1; mem_rdata = 32'h02c00000;
        #3;
        check("s1_inst_data_ok", 32'(inst_data_ok), 32'd1);
        check("s1_inst_rdata", inst_rdata, 32'h02c00000);
        check("s1_data_data_ok", 32'(data_data_ok), 32'd0);
        tick();

        // Both requesters continuously active.
        do_reset();
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            clr(); inst_req = 1'b1; data_req = 1'b1;
            inst_addr = 32'h100 + 32'(i); data_addr = 32'h200 + 32'(i);
            mem_addr_ok = 1'b1; mem_data_ok = (i > 0);
            #3;
            pat = {pat[2:0], data_addr_ok};
            check("s2_one_grant", 32'(inst_addr_ok) + 32'(data_addr_ok), 32'd1);
            tick();
        end
        check("s2_order", 32'(pat), RR_MODE ? 32'h5 : 32'hf);
        clr(); mem_data_ok = 1'b1; tick();

        // Locked data write while inst request appears.
        do_reset();
        clr(); data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
        data_addr = 32'h800; data_wdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            inst_req = (i >= 1); inst_addr = 32'h1000; mem_addr_ok = (i == 3);
            #3;
            check("s3_mem_addr", mem_addr, 32'h800);
            check("s3_mem_wdata", mem_wdata, 32'h12345678);
            check("s3_data_addr_ok", 32'(data_addr_ok), 32'(i == 3));
            check("s3_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
            tick();
        end
        data_req = 1'b0; mem_addr_ok = 1'b1;
        #3;
        check("s3_inst_after", 32'(inst_addr_ok), 32'd1);
        tick();
        clr(); mem_data_ok = 1'b1; tick(); tick();

        // Outstanding limit and in-order response routing.
        do_reset();
        clr(); inst_req = 1'b1; inst_addr = 32'h100; mem_addr_ok = 1'b1; tick();
        clr(); data_req = 1'b1; data_addr = 32'h200; mem_addr_ok = 1'b1; tick();
        clr(); inst_req = 1'b1; inst_addr = 32'h300; mem_addr_ok = 1'b1;
        #3;
        check("s4_full_mem_req", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1'b1;
        #3;
        check("s4_first_inst", 32'(inst_data_ok), 32'd1);
        check("s4_full_pop_req", 32'(mem_req), 32'd0);
        tick();
        #3;
        check("s4_second_data", 32'(data_data_ok), 32'd1);
        check("s4_resume", 32'(inst_addr_ok), 32'd1);
        tick();
        clr(); mem_data_ok = 1'b1;
        #3;
        check("s4_third_inst", 32'(inst_data_ok), 32'd1);
        tick();

        // Spurious response with nothing outstanding.
        do_reset();
        clr(); mem_data_ok = 1'b1;
        #3;
        check("s5_spur_inst", 32'(inst_data_ok), 32'd0);
        check("s5_spur_data", 32'(data_data_ok), 32'd0);
        tick();
        clr(); data_req = 1'b1; data_addr = 32'h40; mem_addr_ok = 1'b1; tick();
        clr(); mem_data_ok = 1'b1; mem_rdata = 32'hcafef00d;
        #3;
        check("s5_data_ok", 32'(data_data_ok), 32'd1);
        check("s5_rdata", data_rdata, 32'hcafef00d);
        tick();

        // Reset with two outstanding discards them.
        do_reset();
        clr(); inst_req = 1'b1; mem_addr_ok = 1'b1; tick();
        clr(); data_req = 1'b1; mem_addr_ok = 1'b1; tick();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            clr(); mem_data_ok = 1'b1;
            #3;
            check("s6_no_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);
            tick();
        end
        clr(); inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
        #3;
        check("s6_issue_ok", 32'(mem_req), 32'd1);
        tick();
        clr(); mem_data_ok = 1'b1; tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
